// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: default word width and bit-counter width helper.
package spi_pkg;

   localparam int unsigned SPI_DEFAULT_W = 10;

   // Width of a counter that indexes bits 0..w-1 of a w-bit word.
   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage : spi_pkg

// File: rtl/spi_sipo_rx_if.sv
// MOSI receive-path bundle between the SPI slave control FSM (master) and spi_sipo_rx (slave).
interface spi_sipo_rx_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DEFAULT_W
);

   localparam int unsigned CNT_W = cnt_w(DATA_W);

   logic              en;
   logic              MOSI;
   logic              clr;
   logic              rx_ack;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic [CNT_W-1:0]  bit_cnt;
   logic              rx_ovr;

   modport master (
      output en, MOSI, clr, rx_ack,
      input  rx_data, rx_valid, busy, bit_cnt, rx_ovr
   );

   modport slave (
      input  en, MOSI, clr, rx_ack,
      output rx_data, rx_valid, busy, bit_cnt, rx_ovr
   );

endinterface : spi_sipo_rx_if

// File: rtl/spi_bit_counter.sv
// Modulo-DATA_W bit counter; wrap flags the increment that closes a word.
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DEFAULT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      inc,
   input  logic                      clr,
   output logic [cnt_w(DATA_W)-1:0]  cnt,
   output logic                      wrap
);

   localparam int unsigned CNT_W = cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   assign wrap = inc & ~clr & (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || wrap) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule : spi_bit_counter

// File: rtl/spi_sipo_rx.sv
// Parametrised SPI MOSI serial-in/parallel-out receiver with valid/ack holding register.
// Define SIPO_OVERRUN_EN to keep the unacknowledged word and raise sticky rx_ovr on overrun.
module spi_sipo_rx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W    = SPI_DEFAULT_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   spi_sipo_rx_if.slave bus
);

   localparam int unsigned CNT_W = cnt_w(DATA_W);

   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] sh_next_c;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic [CNT_W-1:0]  cnt;
   logic              shift_c;
   logic              done_c;

   assign shift_c = bus.en & ~bus.clr;

   // Value the shift register takes if this edge samples MOSI.
   if (MSB_FIRST) begin : g_msb_first
      assign sh_next_c = {sh_q[DATA_W-2:0], bus.MOSI};
   end else begin : g_lsb_first
      assign sh_next_c = {bus.MOSI, sh_q[DATA_W-1:1]};
   end

   spi_bit_counter #(
      .DATA_W (DATA_W)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (shift_c),
      .clr  (bus.clr),
      .cnt  (cnt),
      .wrap (done_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q <= '0;
      end else if (bus.clr) begin
         sh_q <= '0;
      end else if (bus.en) begin
         sh_q <= sh_next_c;
      end
   end

`ifdef SIPO_OVERRUN_EN
   logic ovr_q;
   logic overrun_c;

   assign overrun_c = done_c & valid_q & ~bus.rx_ack;

   // Overrun drops the new word so the consumer still sees the one it has not taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (done_c && !overrun_c) begin
         data_q  <= sh_next_c;
         valid_q <= 1'b1;
      end else if (bus.rx_ack) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_q <= 1'b0;
      end else if (bus.clr) begin
         ovr_q <= 1'b0;
      end else if (overrun_c) begin
         ovr_q <= 1'b1;
      end
   end

   assign bus.rx_ovr = ovr_q;
`else
   // Newest word always wins; a completion outranks a same-cycle ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (done_c) begin
         data_q  <= sh_next_c;
         valid_q <= 1'b1;
      end else if (bus.rx_ack) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.rx_ovr = 1'b0;
`endif

   assign bus.rx_data  = data_q;
   assign bus.rx_valid = valid_q;
   assign bus.bit_cnt  = cnt;
   assign bus.busy     = (cnt != '0);

endmodule : spi_sipo_rx

// File: tb/tb_spi_sipo_rx.sv
// Directed and random checks of spi_sipo_rx at DATA_W 10 (both bit orders), 8 and 16.
module tb_spi_sipo_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic mosi = 1'b0;
   logic clr = 1'b0;
   logic rx_ack = 1'b0;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   spi_sipo_rx_if #(.DATA_W(10)) if10m ();
   spi_sipo_rx_if #(.DATA_W(10)) if10l ();
   spi_sipo_rx_if #(.DATA_W(8))  if8 ();
   spi_sipo_rx_if #(.DATA_W(16)) if16 ();

   assign if10m.en = en;  assign if10m.MOSI = mosi;  assign if10m.clr = clr;  assign if10m.rx_ack = rx_ack;
   assign if10l.en = en;  assign if10l.MOSI = mosi;  assign if10l.clr = clr;  assign if10l.rx_ack = rx_ack;
   assign if8.en   = en;  assign if8.MOSI   = mosi;  assign if8.clr   = clr;  assign if8.rx_ack   = rx_ack;
   assign if16.en  = en;  assign if16.MOSI  = mosi;  assign if16.clr  = clr;  assign if16.rx_ack  = rx_ack;

   spi_sipo_rx #(.DATA_W(10), .MSB_FIRST(1'b1)) dut10m (.clk(clk), .rst(rst), .bus(if10m.slave));
   spi_sipo_rx #(.DATA_W(10), .MSB_FIRST(1'b0)) dut10l (.clk(clk), .rst(rst), .bus(if10l.slave));
   spi_sipo_rx #(.DATA_W(8),  .MSB_FIRST(1'b1)) dut8   (.clk(clk), .rst(rst), .bus(if8.slave));
   spi_sipo_rx #(.DATA_W(16), .MSB_FIRST(1'b0)) dut16  (.clk(clk), .rst(rst), .bus(if16.slave));

`ifdef SIPO_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] sh;
      logic [31:0] data;
      int unsigned cnt;
      bit          valid;
      bit          ovr;
   } mdl_t;

   mdl_t m10m, m10l, m8, m16;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.sh = '0; m.data = '0; m.cnt = 0; m.valid = 1'b0; m.ovr = 1'b0;
      return m;
   endfunction

   // Golden receiver behaviour for a w-bit word, one clock edge.
   function automatic mdl_t mdl_step(mdl_t m, int unsigned w, bit msb, bit e, bit d, bit c, bit a);
      mdl_t        r = m;
      logic [31:0] mask = (32'd1 << w) - 32'd1;
      logic [31:0] nsh;
      bit          done = 1'b0;
      if (c) begin
         r.sh = '0; r.cnt = 0; r.ovr = 1'b0;
      end else if (e) begin
         nsh = msb ? (((m.sh << 1) | 32'(d)) & mask) : ((m.sh >> 1) | (32'(d) << (w - 1)));
         r.sh = nsh;
         if (m.cnt == w - 1) begin
            done = 1'b1;
            r.cnt = 0;
            if (m.valid && !a && OVR_EN) r.ovr = 1'b1;
            else begin r.data = nsh; r.valid = 1'b1; end
         end else begin
            r.cnt = m.cnt + 1;
         end
      end
      if (!done && a) r.valid = 1'b0;
      return r;
   endfunction

   // One clock: inputs applied after a negedge, outputs observed at the next negedge.
   task automatic cycle(input bit e, input bit d, input bit c, input bit a);
      en = e; mosi = d; clr = c; rx_ack = a;
      @(posedge clk);
      m10m = mdl_step(m10m, 10, 1'b1, e, d, c, a);
      m10l = mdl_step(m10l, 10, 1'b0, e, d, c, a);
      m8   = mdl_step(m8,    8, 1'b1, e, d, c, a);
      m16  = mdl_step(m16,  16, 1'b0, e, d, c, a);
      @(negedge clk);
      en = 1'b0; mosi = 1'b0; clr = 1'b0; rx_ack = 1'b0;
   endtask

   // Ten bits of w, sent in order w[9] .. w[0]; ack_last raises rx_ack on the final bit.
   task automatic send_word(input logic [9:0] w, input bit ack_last);
      for (int i = 9; i >= 0; i--) cycle(1'b1, w[i], 1'b0, (i == 0) ? ack_last : 1'b0);
   endtask

   task automatic models_reset();
      m10m = mdl_reset(); m10l = mdl_reset(); m8 = mdl_reset(); m16 = mdl_reset();
   endtask

   task automatic test_reset();
      models_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      nvec++; if (if10m.rx_data !== 10'h000) begin nerr++; $display("FAIL reset_data: got %h want 000", if10m.rx_data); end
      nvec++; if (if10m.rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", if10m.rx_valid); end
      nvec++; if (if10m.bit_cnt !== 4'd0 || if10m.busy !== 1'b0) begin nerr++; $display("FAIL reset_cnt: got %0d/%b want 0/0", if10m.bit_cnt, if10m.busy); end
      nvec++; if (if10m.rx_ovr !== 1'b0) begin nerr++; $display("FAIL reset_ovr: got %b want 0", if10m.rx_ovr); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_bit_order();
      logic [9:0] w = 10'h2CE;
      for (int i = 9; i >= 1; i--) cycle(1'b1, w[i], 1'b0, 1'b0);
      nvec++; if (if10m.bit_cnt !== 4'd9 || if10m.busy !== 1'b1 || if10m.rx_valid !== 1'b0) begin
         nerr++; $display("FAIL order_partial: got cnt %0d busy %b valid %b want 9 1 0", if10m.bit_cnt, if10m.busy, if10m.rx_valid); end
      cycle(1'b1, w[0], 1'b0, 1'b0);
      nvec++; if (if10m.rx_data !== 10'h2CE || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL msb_first: got %h/%b want 2ce/1", if10m.rx_data, if10m.rx_valid); end
      nvec++; if (if10m.bit_cnt !== 4'd0 || if10m.busy !== 1'b0) begin
         nerr++; $display("FAIL msb_cnt_wrap: got %0d/%b want 0/0", if10m.bit_cnt, if10m.busy); end
      nvec++; if (if10l.rx_data !== 10'h1CD || if10l.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL lsb_first: got %h/%b want 1cd/1", if10l.rx_data, if10l.rx_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++; if (if10m.rx_valid !== 1'b0 || if10m.rx_data !== 10'h2CE) begin
         nerr++; $display("FAIL ack_clear: got %h/%b want 2ce/0", if10m.rx_data, if10m.rx_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++; if (if10m.rx_valid !== 1'b0 || if10m.rx_data !== 10'h2CE) begin
         nerr++; $display("FAIL ack_idle: got %h/%b want 2ce/0", if10m.rx_data, if10m.rx_valid); end
   endtask

   task automatic test_gap();
      logic [9:0] w = 10'h2CE;
      for (int i = 9; i >= 6; i--) cycle(1'b1, w[i], 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) cycle(1'b0, ~w[6], 1'b0, 1'b0);
      nvec++; if (if10m.bit_cnt !== 4'd4 || if10m.busy !== 1'b1) begin
         nerr++; $display("FAIL gap_hold: got %0d/%b want 4/1", if10m.bit_cnt, if10m.busy); end
      for (int i = 5; i >= 0; i--) cycle(1'b1, w[i], 1'b0, 1'b0);
      nvec++; if (if10m.rx_data !== 10'h2CE || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL gap_word: got %h/%b want 2ce/1", if10m.rx_data, if10m.rx_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_clr();
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      nvec++; if (if10m.bit_cnt !== 4'd0 || if10m.busy !== 1'b0 || if10m.rx_valid !== 1'b0) begin
         nerr++; $display("FAIL clr_cnt: got cnt %0d busy %b valid %b want 0 0 0", if10m.bit_cnt, if10m.busy, if10m.rx_valid); end
      send_word(10'h155, 1'b0);
      nvec++; if (if10m.rx_data !== 10'h155 || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL clr_msb_word: got %h/%b want 155/1", if10m.rx_data, if10m.rx_valid); end
      nvec++; if (if10l.rx_data !== 10'h2AA) begin
         nerr++; $display("FAIL clr_lsb_word: got %h want 2aa", if10l.rx_data); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      send_word(10'h2CE, 1'b0);
      send_word(10'h0F3, 1'b0);
      nvec++; if (if10m.rx_data !== (OVR_EN ? 10'h2CE : 10'h0F3)) begin
         nerr++; $display("FAIL overrun_data: got %h want %h", if10m.rx_data, OVR_EN ? 10'h2CE : 10'h0F3); end
      nvec++; if (if10m.rx_ovr !== OVR_EN || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL overrun_flag: got ovr %b valid %b want %b 1", if10m.rx_ovr, if10m.rx_valid, OVR_EN); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      nvec++; if (if10m.rx_ovr !== OVR_EN) begin
         nerr++; $display("FAIL overrun_sticky: got %b want %b", if10m.rx_ovr, OVR_EN); end
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      nvec++; if (if10m.rx_ovr !== 1'b0 || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL clr_ovr: got ovr %b valid %b want 0 1", if10m.rx_ovr, if10m.rx_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_ack_same_edge();
      send_word(10'h0F3, 1'b0);
      send_word(10'h2CE, 1'b1);
      nvec++; if (if10m.rx_data !== 10'h2CE || if10m.rx_valid !== 1'b1 || if10m.rx_ovr !== 1'b0) begin
         nerr++; $display("FAIL ack_on_done: got %h valid %b ovr %b want 2ce 1 0", if10m.rx_data, if10m.rx_valid, if10m.rx_ovr); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      models_reset();
      nvec++; if (if10m.rx_data !== 10'h000 || if10m.rx_valid !== 1'b0 || if10m.rx_ovr !== 1'b0) begin
         nerr++; $display("FAIL async_rst_out: got %h valid %b ovr %b want 000 0 0", if10m.rx_data, if10m.rx_valid, if10m.rx_ovr); end
      nvec++; if (if10m.bit_cnt !== 4'd0 || if10m.busy !== 1'b0) begin
         nerr++; $display("FAIL async_rst_cnt: got %0d/%b want 0/0", if10m.bit_cnt, if10m.busy); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_word(10'h155, 1'b0);
      nvec++; if (if10m.rx_data !== 10'h155 || if10m.rx_valid !== 1'b1) begin
         nerr++; $display("FAIL post_rst_word: got %h/%b want 155/1", if10m.rx_data, if10m.rx_valid); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
         nvec++; if (if8.rx_data !== 8'(m8.data) || if8.rx_valid !== m8.valid) begin
            nerr++; $display("FAIL rnd8_data @%0d: got %h/%b want %h/%b", n, if8.rx_data, if8.rx_valid, 8'(m8.data), m8.valid); end
         nvec++; if (if8.bit_cnt !== 3'(m8.cnt) || if8.rx_ovr !== m8.ovr) begin
            nerr++; $display("FAIL rnd8_cnt @%0d: got %0d/%b want %0d/%b", n, if8.bit_cnt, if8.rx_ovr, m8.cnt, m8.ovr); end
         nvec++; if (if16.rx_data !== 16'(m16.data) || if16.rx_valid !== m16.valid) begin
            nerr++; $display("FAIL rnd16_data @%0d: got %h/%b want %h/%b", n, if16.rx_data, if16.rx_valid, 16'(m16.data), m16.valid); end
         nvec++; if (if16.bit_cnt !== 4'(m16.cnt) || if16.rx_ovr !== m16.ovr) begin
            nerr++; $display("FAIL rnd16_cnt @%0d: got %0d/%b want %0d/%b", n, if16.bit_cnt, if16.rx_ovr, m16.cnt, m16.ovr); end
         nvec++; if (if10l.rx_data !== 10'(m10l.data) || if10l.bit_cnt !== 4'(m10l.cnt)) begin
            nerr++; $display("FAIL rnd10l @%0d: got %h/%0d want %h/%0d", n, if10l.rx_data, if10l.bit_cnt, 10'(m10l.data), m10l.cnt); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_bit_order();
      test_gap();
      test_clr();
      test_back_to_back();
      test_ack_same_edge();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_spi_sipo_rx
